uart_transmit: RTL and testbench

//  Serialises 8-bit bytes from the UART TX FIFO onto the tx line as 8N1 frames
//  (optional parity, 1/2 stop bits), LSB first, at a runtime baud set by clk_div.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_bit_timer.sv | 52 +++++
 rtl/uart_transmit.sv | 204 ++++++++++++++++++++
 tb/tb_uart_transmit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encodings, frame constants and
// small helpers used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam logic [31:0] MIN_DIV   = 32'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } uart_state_e;

    // Bit period actually used: anything below MIN_DIV is treated as MIN_DIV.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        if (div < MIN_DIV) begin
            return MIN_DIV;
        end else begin
            return div;
        end
    endfunction

    // Even parity of a data byte (XOR of all bits).
    function automatic logic parity8(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: latches a clamped divisor on load, then counts
// 0..div-1 while run is high and flags bit_end on the last cycle of a bit.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        run,
    input  logic [31:0] div_in,
    output logic        bit_end
);

    logic [31:0] div_q;
    logic [31:0] div_d;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        last_s;

    assign last_s  = (cnt_q == (div_q - 32'd1));
    assign bit_end = run & last_s;

    // Next divisor/counter: load restarts the count, run wraps at div-1.
    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        if (load) begin
            div_d = clamp_div(div_in);
            cnt_d = 32'd0;
        end else if (run) begin
            if (last_s) begin
                cnt_d = 32'd0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end else begin
            cnt_d = 32'd0;
        end
    end

    // Divisor and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= MIN_DIV;
            cnt_q <= 32'd0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmit.sv
// UART transmitter: pops bytes from the TX FIFO and serialises them LSB
// first as start / 8 data / optional parity / 1-2 stop bits. All outputs
// are registered and derived from the next state, so tx falls the cycle
// after a byte is accepted and irq marks the cycle after the last stop bit.
module uart_transmit
    import uart_pkg::*;
#(
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] clk_div,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        tx,
    output logic        irq,
    output logic        busy
);

    localparam logic PAR_EN_B  = (PARITY_EN != 0) ? 1'b1 : 1'b0;
    localparam logic PAR_ODD_B = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

    uart_state_e state_q;
    uart_state_e state_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic [2:0]  idx_q;
    logic [2:0]  idx_d;
    logic        stop_q;
    logic        stop_d;
    logic        par_q;
    logic        par_d;
    logic        tx_q;
    logic        tx_d;
    logic        tx_ready_q;
    logic        tx_ready_d;
    logic        irq_q;
    logic        irq_d;
    logic        busy_q;
    logic        busy_d;

    logic        accept_s;
    logic        run_s;
    logic        bit_end_s;

    assign accept_s = tx_valid & tx_ready_q;

    // Timer runs only while a bit is on the line.
    always_comb begin
        case (state_q)
            ST_START, ST_DATA, ST_PARITY, ST_STOP: run_s = 1'b1;
            default:                               run_s = 1'b0;
        endcase
    end

    uart_bit_timer u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept_s),
        .run     (run_s),
        .div_in  (clk_div),
        .bit_end (bit_end_s)
    );

    // Frame sequencing: next state, shift register, bit index and parity.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        par_d   = par_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    shift_d = tx_data;
                    par_d   = parity8(tx_data) ^ PAR_ODD_B;
                    idx_d   = 3'd0;
                    stop_d  = 1'b0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == IDX_LAST) begin
                        idx_d   = 3'd0;
                        state_d = PAR_EN_B ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                shift_d = 8'd0;
                idx_d   = 3'd0;
                stop_d  = 1'b0;
                par_d   = 1'b0;
            end
        endcase
    end

    // Registered outputs are decoded from the state being entered.
    always_comb begin
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        irq_d      = 1'b0;
        tx_ready_d = 1'b0;
        case (state_d)
            ST_IDLE: begin
                tx_ready_d = 1'b1;
            end
            ST_START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            ST_DATA: begin
                tx_d   = shift_d[0];
                busy_d = 1'b1;
            end
            ST_PARITY: begin
                tx_d   = par_d;
                busy_d = 1'b1;
            end
            ST_STOP: begin
                busy_d = 1'b1;
            end
            ST_DONE: begin
                irq_d = 1'b1;
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers; async reset aborts any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'd0;
            idx_q      <= 3'd0;
            stop_q     <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b0;
            irq_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            stop_q     <= stop_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
            irq_q      <= irq_d;
            busy_q     <= busy_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_q;
    assign irq      = irq_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_transmit.sv
// Testbench for uart_transmit: two instances (8N1, and 8E2 with parity),
// each frame compared cycle by cycle against a waveform computed from the
// frame rules, plus a mid-bit sampling decoder acting as the receiver.
module tb_uart_transmit;

    localparam int PE_A    [2] = '{0, 1};
    localparam int STOPS_A [2] = '{1, 2};
    localparam int ODD         = 0;

    logic        clk;
    logic        rst_n;
    logic [31:0] clk_div_a  [2];
    logic [7:0]  tx_data_a  [2];
    logic [1:0]  tx_valid_a;
    logic [1:0]  tx_ready_w;
    logic [1:0]  tx_w;
    logic [1:0]  irq_w;
    logic [1:0]  busy_w;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_transmit #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_div  (clk_div_a[0]),
        .tx_valid (tx_valid_a[0]),
        .tx_data  (tx_data_a[0]),
        .tx_ready (tx_ready_w[0]),
        .tx       (tx_w[0]),
        .irq      (irq_w[0]),
        .busy     (busy_w[0])
    );

    uart_transmit #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_div  (clk_div_a[1]),
        .tx_valid (tx_valid_a[1]),
        .tx_data  (tx_data_a[1]),
        .tx_ready (tx_ready_w[1]),
        .tx       (tx_w[1]),
        .irq      (irq_w[1]),
        .busy     (busy_w[1])
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {tx, busy, irq, tx_ready} of one instance
    function automatic logic [31:0] obs_of(input int u);
        return {28'd0, tx_w[u], busy_w[u], irq_w[u], tx_ready_w[u]};
    endfunction

    function automatic logic model_parity(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return ((ones % 2) ^ ODD) != 0;
    endfunction

    // Expected line level at cycle t (1-based) after the accepting edge.
    function automatic logic exp_tx(input int u, input logic [7:0] d, input int eff, input int t);
        int k = (t - 1) / eff;
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k - 1];
        if (k == 9 && PE_A[u] == 1) return model_parity(d);
        return 1'b1;
    endfunction

    task automatic send_frame(input int u, input logic [7:0] d, input logic [31:0] div,
                              input bit hold, input logic [7:0] next_d,
                              input logic [31:0] div_after, input int abort_t,
                              output int waited);
        int eff;
        int nbits;
        int len;
        int rxn;
        logic [31:0] e;
        logic [15:0] rx;
        eff   = (div < 32'd2) ? 2 : int'(div);
        nbits = 10 + PE_A[u] + STOPS_A[u] - 1;
        len   = eff * nbits;
        waited = 0;
        while (!tx_ready_w[u] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!tx_ready_w[u]) begin
            chk_eq("ready_timeout", 32'd0, 32'd1);
            return;
        end
        tx_valid_a[u] = 1'b1;
        tx_data_a[u]  = d;
        clk_div_a[u]  = div;
        rx  = 16'd0;
        rxn = 0;
        for (int t = 1; t <= len + 2; t++) begin
            @(negedge clk);
            if (abort_t != 0 && t == abort_t) begin
                rst_n = 1'b0;
                #1;
                chk_eq("abort_now", obs_of(u), 32'h8);
                @(negedge clk);
                chk_eq("abort_hold", obs_of(u), 32'h8);
                rst_n = 1'b1;
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    chk_eq($sformatf("after_abort_%0d", c), obs_of(u), 32'h9);
                end
                return;
            end
            if (t <= len)          e = {28'd0, exp_tx(u, d, eff, t), 3'b100};
            else if (t == len + 1) e = 32'hA;
            else                   e = 32'h9;
            chk_eq($sformatf("u%0d_d%02h_div%0d_t%0d", u, d, eff, t), obs_of(u), e);
            if (t <= len && ((t - 1) % eff) == eff / 2) begin
                rx[rxn] = tx_w[u];
                rxn++;
            end
            if (t == 1) begin
                tx_valid_a[u] = hold;
                tx_data_a[u]  = hold ? next_d : 8'($urandom);
                clk_div_a[u]  = div_after;
            end
        end
        chk_eq("rx_data", {24'd0, rx[8:1]}, {24'd0, d});
        chk_eq("rx_frame", {30'd0, rx[0], rx[nbits - 1]}, 32'd1);
        if (PE_A[u] == 1) begin
            chk_eq("rx_parity", {31'd0, rx[9]}, {31'd0, model_parity(d)});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int u;
        logic [7:0] d;
        logic [31:0] dv;
        rst_n        = 1'b1;
        tx_valid_a   = 2'b00;
        tx_data_a[0] = 8'd0;
        tx_data_a[1] = 8'd0;
        clk_div_a[0] = 32'd4;
        clk_div_a[1] = 32'd4;
        #2 rst_n = 1'b0;
        #1;
        chk_eq("reset_u0", obs_of(0), 32'h8);
        chk_eq("reset_u1", obs_of(1), 32'h8);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 0x55 at div 4: irq lands at accept+41
        send_frame(0, 8'h55, 32'd4, 1'b0, 8'h00, 32'd4, 0, w);
        // clk_div 0 behaves as 2
        send_frame(0, 8'hA3, 32'd0, 1'b0, 8'h00, 32'd0, 0, w);
        // three FIFO bytes with tx_valid held
        send_frame(0, 8'h01, 32'd4, 1'b1, 8'hFF, 32'd4, 0, w);
        send_frame(0, 8'hFF, 32'd4, 1'b1, 8'h80, 32'd4, 0, w);
        chk_eq("b2b_gap1", w, 32'd0);
        send_frame(0, 8'h80, 32'd4, 1'b0, 8'h00, 32'd4, 0, w);
        chk_eq("b2b_gap2", w, 32'd0);
        // divisor change mid-frame applies only to the next frame
        send_frame(0, 8'hC6, 32'd8, 1'b0, 8'h00, 32'd16, 0, w);
        send_frame(0, 8'h5A, 32'd16, 1'b0, 8'h00, 32'd16, 0, w);
        // parity + two stop bits
        send_frame(1, 8'h07, 32'd3, 1'b0, 8'h00, 32'd3, 0, w);
        send_frame(1, 8'h00, 32'd1, 1'b0, 8'h00, 32'd1, 0, w);
        // reset during D3, then a clean frame
        send_frame(0, 8'h3C, 32'd5, 1'b0, 8'h00, 32'd5, 22, w);
        send_frame(0, 8'h9E, 32'd3, 1'b0, 8'h00, 32'd3, 0, w);
        // randomized frames
        for (int i = 0; i < 8; i++) begin
            u  = int'($urandom_range(0, 1));
            d  = 8'($urandom);
            dv = 32'($urandom_range(0, 6));
            send_frame(u, d, dv, 1'b0, 8'h00, dv, 0, w);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
